// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// mem_port_arbiter : round-robin share of one RAM port, optional clear sequence
// Revision 1.0
// =============================================================================
module mem_port_arbiter #(
  parameter int                    NUM_REQ        = 2,
  parameter int                    ADDR_WIDTH     = 6,
  parameter int                    DATA_WIDTH     = 14,
  parameter int                    READ_LATENCY   = 2,
  parameter bit                    CLEAR_ON_RESET = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ-1:0]               i_req_write_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data_in,
  output logic [NUM_REQ-1:0]               o_rsp_valid,
  output logic [DATA_WIDTH-1:0]            o_rsp_data,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  output logic [DATA_WIDTH-1:0]            o_mem_data_in,
  output logic                             o_mem_write_en,
  input  logic [DATA_WIDTH-1:0]            i_mem_data_out,
  output logic                             o_busy
);

  localparam int                  c_PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0]          c_ST_CLEAR  = 1'b0;
  localparam logic [0:0]          c_ST_RUN    = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;
  localparam logic [c_PTR_W:0]    c_NUM_REQ   = (c_PTR_W+1)'(NUM_REQ);
  localparam logic [c_PTR_W-1:0]  c_LAST_REQ  = c_PTR_W'(NUM_REQ-1);

  logic [0:0]                            r_state;
  logic [ADDR_WIDTH-1:0]                 r_clr_cnt;
  logic [c_PTR_W-1:0]                    r_ptr;
  logic [READ_LATENCY-1:0]               r_pipe_vld;
  logic [READ_LATENCY-1:0][c_PTR_W-1:0]  r_pipe_idx;

  logic                  w_run;
  logic                  w_clear;
  logic                  w_found;
  logic [c_PTR_W:0]      w_sum;
  logic [c_PTR_W-1:0]    w_gnt_idx;
  logic [c_PTR_W-1:0]    w_ptr_nxt;
  logic                  w_accept;
  logic                  w_push;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;

  // Outputs are forced quiet while rst is high, whatever the state register holds.
  assign w_run   = (r_state == c_ST_RUN)   && !rst;
  assign w_clear = (r_state == c_ST_CLEAR) && !rst;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (c_PTR_W+1)'(k);
      if (w_sum >= c_NUM_REQ) begin
        w_sum = w_sum - c_NUM_REQ;
      end
      if (!w_found && i_req_valid[w_sum[c_PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[c_PTR_W-1:0];
      end
    end
  end

  assign w_accept   = w_run && w_found;
  assign w_push     = w_accept && !i_req_write_en[w_gnt_idx];
  assign w_ptr_nxt  = (w_gnt_idx == c_LAST_REQ) ? '0 : w_gnt_idx + c_PTR_W'(1);
  assign w_gnt_addr = i_req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_gnt_data = i_req_data_in[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  assign o_req_ready    = w_accept ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign o_mem_addr     = (r_state == c_ST_CLEAR) ? r_clr_cnt   : w_gnt_addr;
  assign o_mem_data_in  = (r_state == c_ST_CLEAR) ? CLEAR_VALUE : w_gnt_data;
  assign o_mem_write_en = w_clear || (w_accept && i_req_write_en[w_gnt_idx]);
  assign o_busy         = (r_state == c_ST_CLEAR);

  // The tail stage of the pipeline lines up with the RAM's read data.
  always_comb begin
    o_rsp_valid = '0;
    if (r_pipe_vld[READ_LATENCY-1] && !rst) begin
      o_rsp_valid[r_pipe_idx[READ_LATENCY-1]] = 1'b1;
    end
  end
  assign o_rsp_data = i_mem_data_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CLEAR_ON_RESET ? c_ST_CLEAR : c_ST_RUN;
      r_clr_cnt  <= '0;
      r_ptr      <= '0;
      r_pipe_vld <= '0;
      r_pipe_idx <= '0;
    end else begin
      if (r_state == c_ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
        if (r_clr_cnt == c_LAST_ADDR) begin
          r_state <= c_ST_RUN;
        end
      end
      if (w_accept) begin
        r_ptr <= w_ptr_nxt;
      end
      r_pipe_vld[0] <= w_push;
      r_pipe_idx[0] <= w_gnt_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// tb_mem_port_arbiter : self-checking bench with a behavioural arbiter model
// Revision 1.0
// =============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 14;
  localparam int NA = 2;
  localparam int LA = 2;
  localparam int NB = 3;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] CV = 14'h155;

  typedef struct packed {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: two requesters, latency 2, clear on reset
  logic              rst_a;
  logic [NA-1:0]     a_valid, a_ready, a_we, a_rsp_valid;
  logic [NA*AW-1:0]  a_addr;
  logic [NA*DW-1:0]  a_din;
  logic [DW-1:0]     a_rsp_data, a_mdin, a_mdout;
  logic [AW-1:0]     a_maddr;
  logic              a_mwe, a_busy;

  // Instance B: three requesters, latency 1, no clear
  logic              rst_b;
  logic [NB-1:0]     b_valid, b_ready, b_we, b_rsp_valid;
  logic [NB*AW-1:0]  b_addr;
  logic [NB*DW-1:0]  b_din;
  logic [DW-1:0]     b_rsp_data, b_mdin, b_mdout;
  logic [AW-1:0]     b_maddr;
  logic              b_mwe, b_busy;

  mem_port_arbiter #(
    .NUM_REQ(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LA),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) u_dut_a (
    .clk(clk), .rst(rst_a),
    .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_write_en(a_we),
    .i_req_addr(a_addr), .i_req_data_in(a_din),
    .o_rsp_valid(a_rsp_valid), .o_rsp_data(a_rsp_data),
    .o_mem_addr(a_maddr), .o_mem_data_in(a_mdin), .o_mem_write_en(a_mwe),
    .i_mem_data_out(a_mdout), .o_busy(a_busy)
  );

  mem_port_arbiter #(
    .NUM_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE('0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b),
    .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_write_en(b_we),
    .i_req_addr(b_addr), .i_req_data_in(b_din),
    .o_rsp_valid(b_rsp_valid), .o_rsp_data(b_rsp_data),
    .o_mem_addr(b_maddr), .o_mem_data_in(b_mdin), .o_mem_write_en(b_mwe),
    .i_mem_data_out(b_mdout), .o_busy(b_busy)
  );

  // RAM models: A has two register stages, B has one
  logic [DW-1:0] a_mem [DEPTH];
  logic [DW-1:0] b_mem [DEPTH];
  logic [DW-1:0] a_rd0, a_rd1;

  always @(posedge clk) begin
    if (a_mwe) a_mem[a_maddr] <= a_mdin;
    a_rd0 <= a_mem[a_maddr];
    a_rd1 <= a_rd0;
  end
  assign a_mdout = a_rd1;

  always @(posedge clk) begin
    if (b_mwe) b_mem[b_maddr] <= b_mdin;
    b_mdout <= b_mem[b_maddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state for instance A
  int            m_ptr  = 0;
  int            m_left = DEPTH;
  int            cyc    = 0;
  logic [DW-1:0] shadow [DEPTH];
  exp_t          q [$];
  int            rsp_count = 0;
  logic [DW-1:0] last_rsp;
  logic [NA-1:0] last_rsp_v;
  logic [NA-1:0] last_ready;

  task automatic a_set(input int i, input bit v, input bit we, input int addr, input int din);
    a_valid[i]           = v;
    a_we[i]              = we;
    a_addr[i*AW +: AW]   = AW'(addr);
    a_din[i*DW +: DW]    = DW'(din);
  endtask

  task automatic a_cycle();
    int   g;
    int   j;
    int   ad;
    logic r;
    @(negedge clk);
    r = rst_a;
    g = -1;
    chk("a_busy", 32'(a_busy), 32'(m_left > 0));
    if (r) begin
      chk("a_rst_ready", 32'(a_ready), 0);
      chk("a_rst_mwe", 32'(a_mwe), 0);
    end else if (m_left > 0) begin
      chk("a_clr_ready", 32'(a_ready), 0);
      chk("a_clr_mwe", 32'(a_mwe), 1);
      chk("a_clr_addr", 32'(a_maddr), DEPTH - m_left);
      chk("a_clr_data", 32'(a_mdin), 32'(CV));
    end else begin
      for (int k = 0; k < NA; k++) begin
        j = (m_ptr + k) % NA;
        if (g < 0 && a_valid[j]) g = j;
      end
      chk("a_ready", 32'(a_ready), (g >= 0) ? (1 << g) : 0);
      if (g >= 0) begin
        chk("a_mwe", 32'(a_mwe), 32'(a_we[g]));
        chk("a_maddr", 32'(a_maddr), 32'(a_addr[g*AW +: AW]));
        if (a_we[g]) chk("a_mdin", 32'(a_mdin), 32'(a_din[g*DW +: DW]));
      end else begin
        chk("a_idle_mwe", 32'(a_mwe), 0);
      end
    end
    if (!r && q.size() > 0 && q[0].due == cyc) begin
      chk("a_rsp_valid", 32'(a_rsp_valid), 1 << q[0].idx);
      chk("a_rsp_data", 32'(a_rsp_data), 32'(q[0].data));
      void'(q.pop_front());
    end else begin
      chk("a_rsp_none", 32'(a_rsp_valid), 0);
    end
    if (a_rsp_valid != '0) begin
      rsp_count++;
      last_rsp   = a_rsp_data;
      last_rsp_v = a_rsp_valid;
    end
    last_ready = a_ready;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ptr  = 0;
      m_left = DEPTH;
    end else if (m_left > 0) begin
      shadow[DEPTH - m_left] = CV;
      m_left--;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NA;
      ad    = int'(a_addr[g*AW +: AW]);
      if (a_we[g]) shadow[ad] = a_din[g*DW +: DW];
      else         q.push_back('{due: cyc + LA, idx: g, data: shadow[ad]});
    end
    cyc++;
    #1;
  endtask

  task automatic b_cycle(input logic [NB-1:0] er, input logic [NB-1:0] ev, input int addr);
    @(negedge clk);
    chk("b_ready", 32'(b_ready), 32'(er));
    chk("b_rsp_valid", 32'(b_rsp_valid), 32'(ev));
    if (ev != '0) chk("b_rsp_data", 32'(b_rsp_data), (addr * 7 + 3) % 16384);
    chk("b_rsp_onehot", 32'($countones(b_rsp_valid) <= 1), 1);
    @(posedge clk);
    #1;
  endtask

  int n;
  int cnt0;

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      a_mem[i] = '0;
      b_mem[i] = DW'((i * 7 + 3) % 16384);
      shadow[i] = '0;
    end
    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = '0; a_we = '0; a_addr = '0; a_din = '0;
    b_valid = '0; b_we = '0; b_addr = '0; b_din = '0;
    @(posedge clk); #1;
    a_cycle(); a_cycle();

    // Clear sequence with a read held pending throughout
    a_set(0, 1, 0, 0, 0);
    rst_a = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 200) begin a_cycle(); n++; end
    chk("clear_len", 32'(n), DEPTH);
    a_cycle();
    a_set(0, 1, 0, 63, 0); a_cycle();
    a_set(0, 0, 0, 0, 0);  a_cycle(); a_cycle();
    chk("clear_rd_count", 32'(rsp_count), 2);
    chk("clear_rd_data", 32'(last_rsp), 32'(CV));

    // Requester 1 alone, then both: pointer wraps to 0, then alternation
    a_set(1, 1, 0, 9, 0);
    repeat (3) begin a_cycle(); chk("r1_only", 32'(last_ready), 2); end
    a_set(0, 1, 0, 5, 0);
    for (int k = 0; k < 6; k++) begin
      a_cycle();
      chk("alt_grant", 32'(last_ready), (k % 2 == 0) ? 1 : 2);
    end
    a_set(0, 0, 0, 0, 0); a_set(1, 0, 0, 0, 0);
    a_cycle(); a_cycle();

    // Write then read of the same address on consecutive accepts
    a_set(0, 1, 1, 17, 'h2AB); a_cycle();
    a_set(0, 0, 0, 0, 0); a_set(1, 1, 0, 17, 0); a_cycle();
    a_set(1, 0, 0, 0, 0); a_cycle(); a_cycle();
    chk("wr_rd_valid", 32'(last_rsp_v), 2);
    chk("wr_rd_data", 32'(last_rsp), 'h2AB);

    // Reset while a read is in flight
    a_set(0, 1, 0, 5, 0); a_cycle();
    cnt0 = rsp_count;
    a_set(0, 0, 0, 0, 0); a_set(1, 1, 0, 9, 0);
    rst_a = 1'b1; a_cycle();
    rst_a = 1'b0; a_set(1, 0, 0, 0, 0);
    n = 0;
    while (a_busy === 1'b1 && n < 200) begin a_cycle(); n++; end
    chk("rst_clear_len", 32'(n), DEPTH);
    chk("rst_flush", 32'(rsp_count), 32'(cnt0));
    a_set(0, 1, 0, 1, 0); a_set(1, 1, 0, 2, 0); a_cycle();
    chk("ptr_after_rst", 32'(last_ready), 1);
    a_set(0, 0, 0, 0, 0); a_set(1, 0, 0, 0, 0);
    repeat (3) a_cycle();

    // Randomized traffic against the model
    repeat (400) begin
      for (int i = 0; i < NA; i++)
        a_set(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 16383)));
      a_cycle();
    end
    a_valid = '0;
    repeat (3) a_cycle();
    chk("a_drain", 32'(q.size()), 0);

    // Instance B: three readers, single-cycle latency
    rst_b = 1'b0;
    b_addr  = {6'd30, 6'd20, 6'd10};
    b_valid = 3'b111;
    b_cycle(3'b001, 3'b000, 0);  b_valid[0] = 1'b0;
    b_cycle(3'b010, 3'b001, 10); b_valid[1] = 1'b0;
    b_cycle(3'b100, 3'b010, 20); b_valid[2] = 1'b0;
    b_cycle(3'b000, 3'b100, 30);
    b_cycle(3'b000, 3'b000, 0);
    chk("b_busy", 32'(b_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
